conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder_pkg.sv | 16 +
 rtl/conv_feeder_buf.sv | 39 +++
 rtl/conv_feeder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_feeder_pkg.sv
// Shared FSM encoding and default geometry for the conv engine feeder.
package conv_feeder_pkg;

    localparam int DEF_PAT_W   = 8;
    localparam int DEF_KER_W   = 8;
    localparam int DEF_PAT_NUM = 64;
    localparam int DEF_KER_NUM = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/conv_feeder_buf.sv
// Single-write buffer with one registered read port; the read register returns 0 when not reading.
module conv_feeder_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left out of reset so contents survive an aborted run.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_feeder.sv
// Streams a stored pattern and a cyclic kernel into the conv engine, then waits for its results.
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int KER_W   = DEF_KER_W,
    parameter int PAT_NUM = DEF_PAT_NUM,
    parameter int KER_NUM = DEF_KER_NUM,
    parameter int TIMEOUT = 1024
) (
    input  logic                                        Aclk,
    input  logic                                        rst_n,
    input  logic                                        wr_en,
    input  logic                                        wr_sel,
    input  logic [$clog2(PAT_NUM)-1:0]                  wr_addr,
    input  logic [((PAT_W > KER_W) ? PAT_W : KER_W)-1:0] wr_data,
    input  logic                                        start,
    input  logic                                        result_done,
    output logic [PAT_W-1:0]                            Xin,
    output logic [KER_W-1:0]                            Kin,
    output logic                                        x_valid,
    output logic                                        busy,
    output logic                                        done,
    output logic [15:0]                                 res_cnt,
    output logic                                        timeout
);

    localparam int PAW = $clog2(PAT_NUM);
    localparam int KAW = (KER_NUM > 1) ? $clog2(KER_NUM) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [PAW:0]   PIDX_END  = (PAW + 1)'(PAT_NUM);
    localparam logic [KAW-1:0] KIDX_LAST = KAW'(KER_NUM - 1);

    state_e         state_q, state_d;
    logic [PAW:0]   pidx_q, pidx_d;
    logic [KAW-1:0] kidx_q, kidx_d;
    logic [TW-1:0]  dcnt_q, dcnt_d;
    logic [15:0]    res_cnt_q, res_cnt_d;
    logic           timeout_q, timeout_d;
    logic           prev_q, prev_d;
    logic           x_valid_q, x_valid_d;
    logic           pat_rd, ker_rd;
    logic           idle;

    assign idle = (state_q == ST_IDLE);

    always_ff @(posedge Aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pidx_q    <= '0;
            kidx_q    <= '0;
            dcnt_q    <= '0;
            res_cnt_q <= '0;
            timeout_q <= 1'b0;
            prev_q    <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pidx_q    <= pidx_d;
            kidx_q    <= kidx_d;
            dcnt_q    <= dcnt_d;
            res_cnt_q <= res_cnt_d;
            timeout_q <= timeout_d;
            prev_q    <= prev_d;
            x_valid_q <= x_valid_d;
        end
    end

    // STREAM spends one extra cycle at PIDX_END so the last word leaves the read register before DRAIN.
    always_comb begin
        state_d   = state_q;
        pidx_d    = pidx_q;
        kidx_d    = kidx_q;
        dcnt_d    = dcnt_q;
        res_cnt_d = res_cnt_q;
        timeout_d = timeout_q;
        prev_d    = result_done;
        x_valid_d = 1'b0;
        pat_rd    = 1'b0;
        ker_rd    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_STREAM;
                    pidx_d    = '0;
                    kidx_d    = '0;
                    dcnt_d    = '0;
                    res_cnt_d = '0;
                    timeout_d = 1'b0;
                    prev_d    = 1'b0;
                end
            end
            ST_STREAM: begin
                ker_rd = 1'b1;
                if (pidx_q == PIDX_END) begin
                    state_d = ST_DRAIN;
                end else begin
                    pat_rd    = 1'b1;
                    x_valid_d = 1'b1;
                    pidx_d    = pidx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (prev_q && !result_done) begin
                    state_d = ST_FIN;
                end else if (dcnt_q == TW'(TIMEOUT)) begin
                    state_d   = ST_FIN;
                    timeout_d = 1'b1;
                end else begin
                    ker_rd = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ker_rd) begin
            kidx_d = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
        end
        if ((state_q == ST_STREAM || state_q == ST_DRAIN) && result_done && res_cnt_q != 16'hFFFF) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end
    end

    conv_feeder_buf #(.WIDTH(PAT_W), .DEPTH(PAT_NUM)) u_pat_buf (
        .clk_i     (Aclk),
        .rst_n_i   (rst_n),
        .wr_en_i   (wr_en && idle && !wr_sel),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data[PAT_W-1:0]),
        .rd_en_i   (pat_rd),
        .rd_addr_i (pidx_q[PAW-1:0]),
        .rd_data_o (Xin)
    );

    conv_feeder_buf #(.WIDTH(KER_W), .DEPTH(KER_NUM)) u_ker_buf (
        .clk_i     (Aclk),
        .rst_n_i   (rst_n),
        .wr_en_i   (wr_en && idle && wr_sel),
        .wr_addr_i (wr_addr[KAW-1:0]),
        .wr_data_i (wr_data[KER_W-1:0]),
        .rd_en_i   (ker_rd),
        .rd_addr_i (kidx_q),
        .rd_data_o (Kin)
    );

    assign x_valid = x_valid_q;
    assign busy    = !idle;
    assign done    = (state_q == ST_FIN);
    assign res_cnt = res_cnt_q;
    assign timeout = timeout_q;

endmodule
